layer_iter_sched: RTL and testbench
===================================

# layer_iter_sched

Sequencer for the layered LDPC decode engine. Once a frame's LLRs are loaded, it steps the Z-wide check-node/variable-node datapath through every layer of every iteration. It times each phase against the check-node pipeline latency and stops early when the external syndrome checker reports a valid codeword. It sits between the LLR input port, the Init configuration tables and the hard-decision/output stage, replacing ad-hoc valid generation in the decoder top level.

## Interface
Parameters:
- NUM_LAYERS, 8: maximum layers per base matrix (all rates).
- WIDTH_LAYER, 3: width of layer index.
- WIDTH_ITERATION, 5: width of iteration counters.
- CHKN_LATENCY, 4: cycles from ChkNInputValid to check-node ValidOut (≥1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- validIn  in  1  LLR block beat present.
- llrInLast  in  1  qualifies the last beat of a frame (only meaningful with validIn).
- numLayers  in  WIDTH_LAYER+1  layers for current rate (from Init NumLayers).
- iterMax  in  WIDTH_ITERATION  maximum iterations; 0 treated as 1.
- syndromeValid  in  1  syndrome result available.
- syndromeOk  in  1  all parity checks satisfied (qualified by syndromeValid).
- outAck  in  1  output stage has consumed the decoded frame.
- CurrLayer  out  WIDTH_LAYER  layer being processed.
- CurrIter  out  WIDTH_ITERATION  1-based iteration index.
- CopyLLRIn2LLRNew  out  1  initialise llr_new from llr_in.
- ChkNInputValid  out  1  launch check nodes for CurrLayer.
- VarNInputValid  out  1  update llr_new with eta_sum.
- ReadyOut  out  1  frame input accepted.
- DecodeDone  out  1  decoded frame ready for hard decision.
- EarlyStop  out  1  frame terminated on syndrome pass.

## Operation
The FSM has states IDLE, LOAD, COPY, CSET, CHK, CWAIT, VAR, VWAIT, SYND and DONE. Each output pulse below lasts exactly one cycle per entry into its state.
- IDLE: ReadyOut=1.
  - validIn & llrInLast → COPY.
  - validIn alone → LOAD.
- LOAD: ReadyOut=1.
  - validIn & llrInLast → COPY.
  - llrInLast without validIn is ignored.
- COPY: CopyLLRIn2LLRNew=1.
  - Latch numLayers (0 → 1; >NUM_LAYERS → NUM_LAYERS) as nL.
  - Latch iterMax (0 → 1) as nI.
  - CurrLayer=0, CurrIter=1 on exit.
  - → CSET.
- CSET: one settle cycle for the registered adder. → CHK.
- CHK: ChkNInputValid=1. → CWAIT.
- CWAIT: down-counter loaded with CHKN_LATENCY-1.
  - Leave for VAR when the counter is 0.
  - With CHKN_LATENCY=1, CWAIT lasts one cycle.
- VAR: VarNInputValid=1. → VWAIT.
- VWAIT: one settle cycle.
  - CurrLayer<nL-1: CurrLayer++ → CHK.
  - Otherwise → SYND.
- SYND: hold until syndromeValid.
  - syndromeOk → DONE with EarlyStop=1.
  - Else, if CurrIter==nI → DONE with EarlyStop=0.
  - Else CurrIter++, CurrLayer=0 → CHK.
- DONE: DecodeDone=1 and EarlyStop held; CurrIter holds the number of iterations executed.
  - outAck → IDLE; DecodeDone and EarlyStop clear on the next cycle.
- ReadyOut=0 in every state except IDLE and LOAD. validIn/llrInLast outside IDLE/LOAD are ignored; they do not queue.
- syndromeValid outside SYND is ignored.
- numLayers/iterMax changes after COPY have no effect on the current frame.

## Timing
- Reset values: state IDLE, CurrLayer=0, CurrIter=0, CopyLLRIn2LLRNew=0, ChkNInputValid=0, VarNInputValid=0, DecodeDone=0, EarlyStop=0, ReadyOut=1.
- Reset asserted mid-frame returns to IDLE on the next edge; counters are cleared and no pulse is emitted.
- All outputs are registered.
- The last beat (validIn & llrInLast at edge T) gives:
  - CopyLLRIn2LLRNew high in cycle T+1.
  - First ChkNInputValid in cycle T+3.
- Per layer: CHKN_LATENCY+3 cycles from ChkNInputValid to the next ChkNInputValid.
- Between ChkNInputValid and VarNInputValid: CHKN_LATENCY+1 cycles.
- Syndrome round-trip: SYND → CHK takes 1 cycle after syndromeValid is sampled.
- DecodeDone rises the cycle after the deciding syndromeValid. It stays high for ≥1 cycle; outAck sampled high in the same cycle DecodeDone first rises is honoured.
- CurrLayer/CurrIter change only on VWAIT/SYND exits and COPY. They are stable throughout CHK..VWAIT.

## Test plan
Bench configuration: CHKN_LATENCY=4.
- **Basic frame:** numLayers=4, iterMax=3, syndromeOk always 0, syndromeValid=1 on SYND entry.
  - 12 ChkNInputValid pulses, each spaced 7 cycles within an iteration.
  - 12 VarNInputValid pulses, each 5 cycles after its ChkNInputValid.
  - DecodeDone with CurrIter=3, EarlyStop=0.
- **Early stop:** same config, syndromeOk=1 at the end of iteration 2.
  - DecodeDone with CurrIter=2, EarlyStop=1.
  - Exactly 8 ChkNInputValid pulses.
- **Clamping:** iterMax=0, numLayers=0.
  - One layer and one iteration.
  - DecodeDone with CurrIter=1.
  - numLayers=15 → 8 layers per iteration.
- **Input handshake:**
  - 8 beats with llrInLast on beat 8 → CopyLLRIn2LLRNew 1 cycle after beat 8.
  - validIn pulses during CHK..DONE are ignored with ReadyOut=0.
  - llrInLast without validIn in LOAD does not start a decode.
- **Syndrome stall / output ack:**
  - syndromeValid delayed 20 cycles → FSM holds in SYND with no pulses.
  - outAck withheld 10 cycles → DecodeDone stays high for 10 cycles; IDLE and ReadyOut=1 follow the cycle after outAck.
- **Reset mid-operation:** reset in CWAIT of iteration 2.
  - All outputs at reset values on the next edge.
  - A new frame afterwards decodes from CurrIter=1, CurrLayer=0.

Source files
------------

// File: rtl/layer_iter_sched.sv
// Layered LDPC decode sequencer: walks every layer of every iteration through the
// check-node / variable-node phases and stops on iteration limit or syndrome pass.
module layer_iter_sched #(
  parameter int NUM_LAYERS      = 8,
  parameter int WIDTH_LAYER     = 3,
  parameter int WIDTH_ITERATION = 5,
  parameter int CHKN_LATENCY    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       validIn,
  input  logic                       llrInLast,
  input  logic [WIDTH_LAYER:0]       numLayers,
  input  logic [WIDTH_ITERATION-1:0] iterMax,
  input  logic                       syndromeValid,
  input  logic                       syndromeOk,
  input  logic                       outAck,
  output logic [WIDTH_LAYER-1:0]     CurrLayer,
  output logic [WIDTH_ITERATION-1:0] CurrIter,
  output logic                       CopyLLRIn2LLRNew,
  output logic                       ChkNInputValid,
  output logic                       VarNInputValid,
  output logic                       ReadyOut,
  output logic                       DecodeDone,
  output logic                       EarlyStop
);
  localparam int CNT_W = (CHKN_LATENCY > 1) ? $clog2(CHKN_LATENCY) : 1;
  localparam logic [CNT_W-1:0]           CNT_LOAD   = CNT_W'(CHKN_LATENCY - 1);
  localparam logic [CNT_W-1:0]           CNT_ONE    = CNT_W'(1);
  localparam logic [WIDTH_LAYER:0]       LAYERS_MAX = (WIDTH_LAYER + 1)'(NUM_LAYERS);
  localparam logic [WIDTH_LAYER:0]       LAYER_ONE  = (WIDTH_LAYER + 1)'(1);
  localparam logic [WIDTH_LAYER-1:0]     LAYER_INC  = WIDTH_LAYER'(1);
  localparam logic [WIDTH_ITERATION-1:0] ITER_ONE   = WIDTH_ITERATION'(1);

  typedef enum logic [3:0] {
    IDLE, LOAD, COPY, CSET, CHK, CWAIT, VAR, VWAIT, SYND, DONE
  } state_t;

  state_t                     state_reg;
  logic [WIDTH_LAYER:0]       nl_reg;
  logic [WIDTH_ITERATION-1:0] ni_reg;
  logic [CNT_W-1:0]           cnt_reg;
  logic                       last_layer;
  logic                       last_iter;

  // nl_reg is never 0, so the widened increment cannot wrap
  assign last_layer = ({1'b0, CurrLayer} + LAYER_ONE) >= nl_reg;
  assign last_iter  = (CurrIter == ni_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      nl_reg           <= LAYER_ONE;
      ni_reg           <= ITER_ONE;
      cnt_reg          <= '0;
      CurrLayer        <= '0;
      CurrIter         <= '0;
      CopyLLRIn2LLRNew <= 1'b0;
      ChkNInputValid   <= 1'b0;
      VarNInputValid   <= 1'b0;
      ReadyOut         <= 1'b1;
      DecodeDone       <= 1'b0;
      EarlyStop        <= 1'b0;
    end else begin
      // pulse outputs are raised only on the transition into their state
      CopyLLRIn2LLRNew <= 1'b0;
      ChkNInputValid   <= 1'b0;
      VarNInputValid   <= 1'b0;
      case (state_reg)
        IDLE, LOAD: begin
          if (validIn) begin
            if (llrInLast) begin
              state_reg        <= COPY;
              CopyLLRIn2LLRNew <= 1'b1;
              ReadyOut         <= 1'b0;
            end else begin
              state_reg <= LOAD;
            end
          end
        end
        COPY: begin
          if (numLayers == '0)            nl_reg <= LAYER_ONE;
          else if (numLayers > LAYERS_MAX) nl_reg <= LAYERS_MAX;
          else                            nl_reg <= numLayers;
          ni_reg    <= (iterMax == '0) ? ITER_ONE : iterMax;
          CurrLayer <= '0;
          CurrIter  <= ITER_ONE;
          state_reg <= CSET;
        end
        CSET: begin
          state_reg      <= CHK;
          ChkNInputValid <= 1'b1;
        end
        CHK: begin
          state_reg <= CWAIT;
          cnt_reg   <= CNT_LOAD;
        end
        CWAIT: begin
          if (cnt_reg == '0) begin
            state_reg      <= VAR;
            VarNInputValid <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        VAR: state_reg <= VWAIT;
        VWAIT: begin
          if (last_layer) begin
            state_reg <= SYND;
          end else begin
            CurrLayer      <= CurrLayer + LAYER_INC;
            state_reg      <= CHK;
            ChkNInputValid <= 1'b1;
          end
        end
        SYND: begin
          if (syndromeValid) begin
            if (syndromeOk || last_iter) begin
              state_reg  <= DONE;
              DecodeDone <= 1'b1;
              EarlyStop  <= syndromeOk;
            end else begin
              CurrIter       <= CurrIter + ITER_ONE;
              CurrLayer      <= '0;
              state_reg      <= CHK;
              ChkNInputValid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (outAck) begin
            state_reg  <= IDLE;
            DecodeDone <= 1'b0;
            EarlyStop  <= 1'b0;
            ReadyOut   <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_iter_sched.sv
// Self-checking bench for layer_iter_sched: a cycle-timeline model of each frame
// predicts every output pulse, which is compared against the DUT cycle by cycle.
module tb_layer_iter_sched;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       reset, validIn, llrInLast, syndromeValid, syndromeOk, outAck;
  logic [3:0] numLayers;
  logic [4:0] iterMax;
  logic [2:0] CurrLayer;
  logic [4:0] CurrIter;
  logic       CopyLLRIn2LLRNew, ChkNInputValid, VarNInputValid;
  logic       ReadyOut, DecodeDone, EarlyStop;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Expected timeline of one frame, keyed by absolute cycle number
  bit exp_chk[int];
  bit exp_var[int];
  int exp_layer[int];
  int exp_iter[int];
  bit syn_dec[int];
  bit synd_busy[int];

  layer_iter_sched #(
    .NUM_LAYERS(8), .WIDTH_LAYER(3), .WIDTH_ITERATION(5), .CHKN_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .validIn(validIn), .llrInLast(llrInLast),
    .numLayers(numLayers), .iterMax(iterMax), .syndromeValid(syndromeValid),
    .syndromeOk(syndromeOk), .outAck(outAck), .CurrLayer(CurrLayer),
    .CurrIter(CurrIter), .CopyLLRIn2LLRNew(CopyLLRIn2LLRNew),
    .ChkNInputValid(ChkNInputValid), .VarNInputValid(VarNInputValid),
    .ReadyOut(ReadyOut), .DecodeDone(DecodeDone), .EarlyStop(EarlyStop)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d (required: finish earlier)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    validIn = 1'b0; llrInLast = 1'b0; syndromeValid = 1'b0; syndromeOk = 1'b0;
    outAck = 1'b0; numLayers = 4'd0; iterMax = 5'd0;
  endtask

  // Loads a frame, predicts its timeline, then drives noise and syndrome replies
  // while comparing every output on every cycle until the frame is acknowledged.
  task automatic run_frame(input logic [3:0] nl_in, input logic [4:0] im_in,
                           input int ok_iter, input int delay, input int ack_delay,
                           input int nbeats, input bit gaps, input bit rst_mid,
                           output int n_chk, output int n_var,
                           output logic [4:0] done_iter, output logic done_early);
    int nl, ni, t, se, sd, d, td, t_end, t_copy, k_stop, rst_at;
    bit early, stop;
    logic e_copy, e_chk, e_var, e_done, e_early, e_ready;
    logic [2:0] e_layer;
    logic [4:0] e_iter;
    exp_chk.delete(); exp_var.delete(); exp_layer.delete(); exp_iter.delete();
    syn_dec.delete(); synd_busy.delete();
    n_chk = 0; n_var = 0; done_iter = 'x; done_early = 1'bx;
    rst_at = -1; k_stop = 0; early = 1'b0; td = 0; stop = 1'b0;

    for (int b = 1; b <= nbeats; b++) begin
      if (gaps || $urandom_range(0, 3) == 0) begin
        validIn = 1'b0; llrInLast = 1'b1; numLayers = nl_in; iterMax = im_in;
        tick();
        checks++;
        if (ReadyOut !== 1'b1 || CopyLLRIn2LLRNew !== 1'b0) begin
          failures++;
          $display("FAIL load_gap cyc=%0d ready=%b copy=%b required ready=1 copy=0",
                   cyc, ReadyOut, CopyLLRIn2LLRNew);
        end
      end
      validIn = 1'b1; llrInLast = (b == nbeats); numLayers = nl_in; iterMax = im_in;
      syndromeValid = 1'b0; syndromeOk = 1'b0; outAck = 1'b0;
      tick();
      if (b < nbeats) begin
        checks++;
        if (ReadyOut !== 1'b1 || CopyLLRIn2LLRNew !== 1'b0) begin
          failures++;
          $display("FAIL load_beat cyc=%0d ready=%b copy=%b required ready=1 copy=0",
                   cyc, ReadyOut, CopyLLRIn2LLRNew);
        end
      end
    end
    t_copy = cyc;

    // Timeline model: first check-node launch 2 cycles after the copy cycle,
    // layers every LAT+3 cycles, SYND entered LAT+3 after the last launch.
    nl = (nl_in == 0) ? 1 : ((nl_in > 8) ? 8 : int'(nl_in));
    ni = (im_in == 0) ? 1 : int'(im_in);
    t = t_copy + 2;
    for (int k = 1; k <= ni && !stop; k++) begin
      for (int j = 0; j < nl; j++) begin
        exp_chk[t] = 1'b1;
        exp_var[t + LAT + 1] = 1'b1;
        for (int c = t; c <= t + LAT + 2; c++) begin
          exp_layer[c] = j;
          exp_iter[c] = k;
        end
        if (k == 2 && j == 0) rst_at = t + 2;
        if (j < nl - 1) t += LAT + 3;
      end
      se = t + LAT + 3;
      d = (delay >= 0) ? delay : int'($urandom_range(0, 5));
      sd = se + d;
      for (int c = se; c < sd; c++) synd_busy[c] = 1'b1;
      syn_dec[sd] = (k == ok_iter);
      if (k == ok_iter || k == ni) begin
        td = sd + 1;
        early = (k == ok_iter);
        k_stop = k;
        stop = 1'b1;
      end else begin
        t = sd + 1;
      end
    end
    t_end = td + ack_delay + 1;

    while (1) begin
      e_copy  = (cyc == t_copy);
      e_chk   = exp_chk.exists(cyc);
      e_var   = exp_var.exists(cyc);
      e_done  = (cyc >= td && cyc <= td + ack_delay);
      e_early = e_done && early;
      e_ready = (cyc >= t_end);
      if (ChkNInputValid === 1'b1) n_chk++;
      if (VarNInputValid === 1'b1) n_var++;
      if (cyc == td) begin done_iter = CurrIter; done_early = EarlyStop; end

      checks++;
      if (CopyLLRIn2LLRNew !== e_copy) begin failures++;
        $display("FAIL copy cyc=%0d got=%b required=%b", cyc, CopyLLRIn2LLRNew, e_copy); end
      checks++;
      if (ChkNInputValid !== e_chk) begin failures++;
        $display("FAIL chk cyc=%0d got=%b required=%b", cyc, ChkNInputValid, e_chk); end
      checks++;
      if (VarNInputValid !== e_var) begin failures++;
        $display("FAIL var cyc=%0d got=%b required=%b", cyc, VarNInputValid, e_var); end
      checks++;
      if (ReadyOut !== e_ready) begin failures++;
        $display("FAIL ready cyc=%0d got=%b required=%b", cyc, ReadyOut, e_ready); end
      checks++;
      if (DecodeDone !== e_done) begin failures++;
        $display("FAIL done cyc=%0d got=%b required=%b", cyc, DecodeDone, e_done); end
      checks++;
      if (EarlyStop !== e_early) begin failures++;
        $display("FAIL early cyc=%0d got=%b required=%b", cyc, EarlyStop, e_early); end
      if (exp_layer.exists(cyc)) begin
        e_layer = 3'(exp_layer[cyc]);
        e_iter  = 5'(exp_iter[cyc]);
        checks++;
        if (CurrLayer !== e_layer || CurrIter !== e_iter) begin failures++;
          $display("FAIL layer_iter cyc=%0d got=%0d/%0d required=%0d/%0d",
                   cyc, CurrLayer, CurrIter, e_layer, e_iter); end
      end
      if (e_done) begin
        checks++;
        if (CurrIter !== 5'(k_stop)) begin failures++;
          $display("FAIL done_iter cyc=%0d got=%0d required=%0d", cyc, CurrIter, k_stop); end
      end
      if (cyc == t_end) break;

      if (rst_mid && cyc == rst_at) begin
        idle_inputs();
        validIn = 1'b1; llrInLast = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        checks++;
        if (CurrLayer !== 3'd0 || CurrIter !== 5'd0 || CopyLLRIn2LLRNew !== 1'b0 ||
            ChkNInputValid !== 1'b0 || VarNInputValid !== 1'b0 || ReadyOut !== 1'b1 ||
            DecodeDone !== 1'b0 || EarlyStop !== 1'b0) begin
          failures++;
          $display("FAIL rst_mid cyc=%0d got L=%0d I=%0d cp=%b ck=%b vr=%b rdy=%b dn=%b es=%b required 0/0/0/0/0/1/0/0",
                   cyc, CurrLayer, CurrIter, CopyLLRIn2LLRNew, ChkNInputValid,
                   VarNInputValid, ReadyOut, DecodeDone, EarlyStop);
        end
        $display("frame nl=%0d ni=%0d reset at cyc=%0d", nl, ni, cyc);
        return;
      end

      // Inputs for the edge that ends this cycle
      if (cyc == t_copy) begin
        numLayers = nl_in; iterMax = im_in;
      end else begin
        numLayers = 4'($urandom); iterMax = 5'($urandom);
      end
      validIn = (cyc <= td + ack_delay) ? ($urandom_range(0, 2) == 0) : 1'b0;
      llrInLast = 1'($urandom_range(0, 1));
      if (syn_dec.exists(cyc)) begin
        syndromeValid = 1'b1; syndromeOk = syn_dec[cyc];
      end else if (synd_busy.exists(cyc)) begin
        syndromeValid = 1'b0; syndromeOk = 1'($urandom_range(0, 1));
      end else begin
        syndromeValid = ($urandom_range(0, 3) == 0); syndromeOk = 1'($urandom_range(0, 1));
      end
      outAck = (cyc == td + ack_delay);
      tick();
    end
    idle_inputs();

    checks++;
    if (n_chk != nl * k_stop || n_var != nl * k_stop) begin failures++;
      $display("FAIL pulse_count chk=%0d var=%0d required=%0d", n_chk, n_var, nl * k_stop); end
    $display("frame nl=%0d ni=%0d iters=%0d early=%0d chk=%0d var=%0d done_iter=%0d",
             nl, ni, k_stop, early, n_chk, n_var, done_iter);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (ReadyOut !== 1'b1) begin failures++;
      $display("FAIL reset_ready got=%b required=1", ReadyOut); end
    checks++;
    if (CurrLayer !== 3'd0 || CurrIter !== 5'd0) begin failures++;
      $display("FAIL reset_counters got=%0d/%0d required=0/0", CurrLayer, CurrIter); end
    checks++;
    if ({CopyLLRIn2LLRNew, ChkNInputValid, VarNInputValid, DecodeDone, EarlyStop} !== 5'b0) begin
      failures++;
      $display("FAIL reset_pulses got=%b required=00000",
               {CopyLLRIn2LLRNew, ChkNInputValid, VarNInputValid, DecodeDone, EarlyStop});
    end
    reset = 1'b0;
    tick();
    checks++;
    if (ReadyOut !== 1'b1 || ChkNInputValid !== 1'b0) begin failures++;
      $display("FAIL idle_hold ready=%b chk=%b required ready=1 chk=0", ReadyOut, ChkNInputValid); end
    $display("reset done");
  endtask

  task automatic test_basic_frame();
    int nc, nv; logic [4:0] di; logic de;
    run_frame(4'd4, 5'd3, 0, 0, int'($urandom_range(0, 3)), 4, 1'b0, 1'b0, nc, nv, di, de);
    checks++;
    if (nc != 12 || nv != 12) begin failures++;
      $display("FAIL basic_counts chk=%0d var=%0d required=12/12", nc, nv); end
    checks++;
    if (di !== 5'd3 || de !== 1'b0) begin failures++;
      $display("FAIL basic_done iter=%0d early=%b required=3/0", di, de); end
  endtask

  task automatic test_early_stop();
    int nc, nv; logic [4:0] di; logic de;
    run_frame(4'd4, 5'd3, 2, 0, 1, 3, 1'b0, 1'b0, nc, nv, di, de);
    checks++;
    if (nc != 8) begin failures++;
      $display("FAIL early_count chk=%0d required=8", nc); end
    checks++;
    if (di !== 5'd2 || de !== 1'b1) begin failures++;
      $display("FAIL early_done iter=%0d early=%b required=2/1", di, de); end
  endtask

  task automatic test_clamping();
    int nc, nv; logic [4:0] di; logic de;
    run_frame(4'd0, 5'd0, 0, 1, 0, 2, 1'b0, 1'b0, nc, nv, di, de);
    checks++;
    if (nc != 1 || di !== 5'd1) begin failures++;
      $display("FAIL clamp_min chk=%0d iter=%0d required=1/1", nc, di); end
    run_frame(4'd15, 5'd2, 0, 0, 2, 1, 1'b0, 1'b0, nc, nv, di, de);
    checks++;
    if (nc != 16 || di !== 5'd2) begin failures++;
      $display("FAIL clamp_max chk=%0d iter=%0d required=16/2", nc, di); end
  endtask

  task automatic test_input_handshake();
    int nc, nv; logic [4:0] di; logic de;
    run_frame(4'd2, 5'd1, 0, 0, 1, 8, 1'b1, 1'b0, nc, nv, di, de);
    checks++;
    if (nc != 2) begin failures++;
      $display("FAIL handshake_count chk=%0d required=2", nc); end
  endtask

  task automatic test_synd_stall_ack();
    int nc, nv; logic [4:0] di; logic de;
    run_frame(4'd3, 5'd2, 0, 20, 9, 2, 1'b0, 1'b0, nc, nv, di, de);
    checks++;
    if (nc != 6 || di !== 5'd2) begin failures++;
      $display("FAIL stall_done chk=%0d iter=%0d required=6/2", nc, di); end
  endtask

  task automatic test_reset_mid();
    int nc, nv; logic [4:0] di; logic de;
    run_frame(4'd4, 5'd3, 0, 0, 0, 2, 1'b0, 1'b1, nc, nv, di, de);
    run_frame(4'd3, 5'd2, 0, 0, 0, 1, 1'b0, 1'b0, nc, nv, di, de);
    checks++;
    if (nc != 6 || di !== 5'd2) begin failures++;
      $display("FAIL after_reset chk=%0d iter=%0d required=6/2", nc, di); end
  endtask

  task automatic test_random();
    int nc, nv; logic [4:0] di; logic de;
    for (int i = 0; i < 8; i++)
      run_frame(4'($urandom), 5'($urandom_range(0, 4)), int'($urandom_range(0, 4)), -1,
                int'($urandom_range(0, 4)), int'($urandom_range(1, 5)),
                1'($urandom_range(0, 1)), 1'b0, nc, nv, di, de);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_basic_frame();
    test_early_stop();
    test_clamping();
    test_input_handshake();
    test_synd_stall_ack();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
